// File: rtl/pp_acc_pkg.sv
// Shared types and elaboration helpers for the partial-product accumulator.
// Parameter legality is checked by each instantiating module against params_ok().
package pp_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } pp_state_t;

  // Width of a fully shifted term, plus one spare bit so the adder sees a clean zero MSB.
  function automatic int term_width(input int in_w, input int digit_w, input int shift_w);
    return in_w + digit_w * ((1 << shift_w) - 1) + 1;
  endfunction

  function automatic bit params_ok(input int in_w, input int acc_w, input int terms);
    return (acc_w >= in_w) && (terms >= 1);
  endfunction

endpackage

// File: rtl/pp_shift_align.sv
// Zero-extends a partial product and shifts it left by a whole number of digits.
// Purely combinational: one candidate per possible shift, then a select.
module pp_shift_align
  import pp_acc_pkg::*;
#(
  parameter int IN_W    = 16,
  parameter int DIGIT_W = 4,
  parameter int SHIFT_W = 2,
  parameter int TERM_W  = term_width(IN_W, DIGIT_W, SHIFT_W)
) (
  input  logic [IN_W-1:0]    in_data,
  input  logic [SHIFT_W-1:0] in_shift,
  output logic [TERM_W-1:0]  term
);

  localparam int NSHIFT = 1 << SHIFT_W;

  logic [TERM_W-1:0] ext;
  logic [TERM_W-1:0] cand [NSHIFT];

  assign ext = {{(TERM_W-IN_W){1'b0}}, in_data};

  for (genvar gi = 0; gi < NSHIFT; gi++) begin : g_cand
    assign cand[gi] = ext << (gi * DIGIT_W);
  end

  assign term = cand[in_shift];

endmodule

// File: rtl/pp_accumulator.sv
// Accumulates digit-aligned partial products into a wide sum with sticky overflow,
// then holds the result on a valid/ready output until the consumer takes it.
module pp_accumulator
  import pp_acc_pkg::*;
#(
  parameter int IN_W    = 16,
  parameter int DIGIT_W = 4,
  parameter int SHIFT_W = 2,
  parameter int ACC_W   = 32,
  parameter int TERMS   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    in_data,
  input  logic [SHIFT_W-1:0] in_shift,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_data,
  output logic               out_ovf,
  output logic               busy
);

  localparam int TERM_W = term_width(IN_W, DIGIT_W, SHIFT_W);
  localparam int SUM_W  = ((ACC_W > TERM_W) ? ACC_W : TERM_W) + 1;
  localparam int CNT_W  = (TERMS > 1) ? $clog2(TERMS) : 1;

  if (!params_ok(IN_W, ACC_W, TERMS)) begin : g_param_check
    $error("pp_accumulator: requires ACC_W >= IN_W and TERMS >= 1");
  end

  pp_state_t          state_reg, state_next;
  logic [ACC_W-1:0]   acc_reg;
  logic               ovf_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [ACC_W-1:0]   out_data_reg;
  logic               out_ovf_reg;

  logic [TERM_W-1:0]  term;
  logic [SUM_W-1:0]   sum;
  logic               sum_hi;
  logic               clear;
  logic               beat;
  logic               final_beat;

  pp_shift_align #(
    .IN_W    (IN_W),
    .DIGIT_W (DIGIT_W),
    .SHIFT_W (SHIFT_W),
    .TERM_W  (TERM_W)
  ) u_align (
    .in_data  (in_data),
    .in_shift (in_shift),
    .term     (term)
  );

  assign sum    = {{(SUM_W-ACC_W){1'b0}}, acc_reg} + {{(SUM_W-TERM_W){1'b0}}, term};
  assign sum_hi = |sum[SUM_W-1:ACC_W];

  // A start in HOLD only counts when the result is being taken in the same cycle.
  assign clear = start && ((state_reg == IDLE) || (state_reg == ACCUM) ||
                           ((state_reg == HOLD) && out_ready));
  assign beat       = (state_reg == ACCUM) && in_valid && !start;
  assign final_beat = beat && (in_last || (cnt_reg == CNT_W'(TERMS - 1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) state_next = ACCUM;
      end
      ACCUM: begin
        if (start)           state_next = ACCUM;
        else if (final_beat) state_next = HOLD;
      end
      HOLD: begin
        if (out_ready) state_next = start ? ACCUM : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_reg)
      ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      HOLD: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg      <= '0;
      ovf_reg      <= 1'b0;
      cnt_reg      <= '0;
      out_data_reg <= '0;
      out_ovf_reg  <= 1'b0;
    end else if (clear) begin
      acc_reg <= '0;
      ovf_reg <= 1'b0;
      cnt_reg <= '0;
    end else if (beat) begin
      acc_reg <= sum[ACC_W-1:0];
      ovf_reg <= ovf_reg | sum_hi;
      cnt_reg <= cnt_reg + CNT_W'(1);
      // The result registers capture the post-update value so HOLD shows the final sum.
      if (final_beat) begin
        out_data_reg <= sum[ACC_W-1:0];
        out_ovf_reg  <= ovf_reg | sum_hi;
      end
    end
  end

  assign out_data = out_data_reg;
  assign out_ovf  = out_ovf_reg;

endmodule

// File: doc/pp_accumulator.md
Name: pp_accumulator

Overview:
- Parametrised partial-product accumulator for the hex multiplier datapath; successor to the fixed 16-bit accumulate-and-clear adder.
- Accepts shifted partial products over a valid/ready stream, aligns each one by a per-beat digit offset and sums them into a wide accumulator.
- Presents the final sum with a sticky overflow flag on a valid/ready output and holds it until the consumer accepts it.
- Sits between the digit-product generator and the result register/output stage.

Parameters:
- IN_W, 16, width of each incoming partial product.
- DIGIT_W, 4, bits per shift unit (one hex digit).
- SHIFT_W, 2, width of the per-beat shift field; maximum shift is 2**SHIFT_W-1 digits.
- ACC_W, 32, accumulator and result width; must be >= IN_W.
- TERMS, 4, maximum beats per result; must be >= 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a new accumulation and clears the accumulator.
- in_valid  in  1  partial-product beat valid.
- in_ready  out  1  block accepts a beat; high only in ACCUM.
- in_data  in  IN_W  partial product, unsigned.
- in_shift  in  SHIFT_W  left shift of in_data, in digits.
- in_last  in  1  marks the final beat of the current result.
- out_valid  out  1  result available; high only in HOLD.
- out_ready  in  1  consumer accepts the result.
- out_data  out  ACC_W  accumulated result.
- out_ovf  out  1  sticky flag: some carry or shifted bit exceeded ACC_W during this result.
- busy  out  1  high in ACCUM or HOLD.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, acc=0, ovf=0, cnt=0. in_ready, out_valid, busy, out_data and out_ovf are all 0.
- FSM states are IDLE, ACCUM and HOLD.
- IDLE:
  - in_ready=0, out_valid=0.
  - If start=1: next state is ACCUM, with acc<=0, ovf<=0, cnt<=0.
- ACCUM:
  - in_ready=1. A beat is accepted when in_valid and in_ready are both 1.
  - On an accepted beat:
    - term = zero-extended in_data << (in_shift*DIGIT_W), computed at width IN_W+DIGIT_W*(2**SHIFT_W-1)+1.
    - sum = acc + term.
    - acc <= sum mod 2**ACC_W.
    - ovf <= ovf | (any sum bit at or above ACC_W).
    - cnt <= cnt+1.
  - If the accepted beat has in_last=1, or cnt==TERMS-1, next state is HOLD. out_data and out_ovf take the post-update values, so out_valid rises the cycle after the last beat.
  - If start=1 in ACCUM: the block aborts and restarts. acc, ovf and cnt are cleared, it stays in ACCUM, and any beat handshaking in that cycle is dropped.
- HOLD:
  - out_valid=1, in_ready=0. out_data and out_ovf are stable until the handshake.
  - When out_valid and out_ready are both 1: next state is IDLE. If start=1 in the same cycle, next state is ACCUM with acc, ovf and cnt cleared, so back-to-back results lose no cycle.
  - start without out_ready in HOLD is ignored; the result is never lost.
- Outputs:
  - out_data and out_ovf are registered. They keep their last value in IDLE; only out_valid qualifies them.
  - busy = (state != IDLE).
- Boundary conditions:
  - A beat with in_data=0 still counts toward TERMS.
  - in_valid outside ACCUM has no effect.
  - A shift that pushes bits past ACC_W sets ovf even when the sum has no carry.
  - Reset mid-operation discards all state immediately, with no out_valid pulse.

Decomposition:
- Package pp_acc_pkg: state enum (IDLE, ACCUM, HOLD), localparam function for the aligned term width, and elaboration checks (ACC_W >= IN_W, TERMS >= 1).
- Sub-module pp_shift_align: combinational zero-extend and digit shift of in_data by in_shift; no state.
- The top holds the FSM, accumulator, beat counter and output registers.

Test Plan:
- Four-beat shifted sum: start, then beats 0x00FF with shifts 0,1,2,3, with in_last on the 4th. Required: out_valid one cycle after the 4th beat, out_data=0x0010FFEF, out_ovf=0.
- Overflow (ACC_W=20): beats 0xFFFF shift 1, then 0x0010 shift 0 with in_last. Required: out_data=0x00000, out_ovf=1.
- TERMS cap: four beats of 0x0001 shift 0, never asserting in_last. Required: HOLD entered after the 4th beat, out_data=4, in_ready=0.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD while pulsing start. Required: out_data stable, start ignored. Then raise out_ready together with start: next state ACCUM, acc=0.
- Abort: after 2 beats of 0x0100, pulse start with a simultaneous beat, then send 0x0003 with in_last. Required: out_data=0x3 (dropped beat absent), out_ovf=0.
- Reset mid-ACCUM: drop rst_n after 1 beat. Required: outputs 0 immediately, IDLE. After release, a fresh start plus beat 0x0007 with in_last gives out_data=7.
